// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: shared types, limits and helpers for the UART receive-frame shift register
package rx_frame_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_mode_t;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} rx_state_t;
  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/rx_frame_sr_if.sv
// rx_frame_sr_if: strobe/serial inputs and completed-word handshake of rx_frame_sr
interface rx_frame_sr_if #(parameter int DATA_BITS = 8) ();
  logic frame_start;
  logic shift_strobe;
  logic serial_in;
  logic data_read;
  logic [DATA_BITS-1:0] packet_data;
  logic data_valid;
  logic frame_done;
  logic framing_error;
  logic parity_error;
  logic overrun_error;
  logic busy;
  modport master (
    output frame_start, shift_strobe, serial_in, data_read,
    input packet_data, data_valid, frame_done, framing_error, parity_error, overrun_error, busy
  );
  modport slave (
    input frame_start, shift_strobe, serial_in, data_read,
    output packet_data, data_valid, frame_done, framing_error, parity_error, overrun_error, busy
  );
endinterface

// File: rtl/rx_bit_counter.sv
// rx_bit_counter: strobe-enabled counter with sync clear and terminal-count compare
module rx_bit_counter #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         hit
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    hit = en && cnt_q == term;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rx_frame_sr.sv
// rx_frame_sr: UART receive-frame capture with stop/parity checks and valid/read handshake
// Optional parity slot and checking are built only when RX_PARITY_EN is defined.
module rx_frame_sr import rx_frame_pkg::*; #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter parity_mode_t PARITY_MODE = PAR_NONE
) (
  input logic clk,
  input logic rst,
  rx_frame_sr_if.slave bus
);
  localparam int CW = $clog2(max2(DATA_BITS, STOP_BITS) + 1);
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit USE_PAR = PAR_EN && PARITY_MODE != PAR_NONE;
  rx_state_t state_q, state_d;
  logic [DATA_BITS-1:0] sr_q, sr_d, packet_data_q, packet_data_d;
  logic stop_ok_q, stop_ok_d;
  logic data_valid_q, data_valid_d, frame_done_q, frame_done_d;
  logic framing_error_q, framing_error_d, parity_error_q, parity_error_d;
  logic overrun_error_q, overrun_error_d;
  logic hit, cnt_en, done, par_err;
  logic [CW-1:0] term;
  rx_bit_counter #(.W(CW)) u_cnt (
    .clk(clk), .rst(rst), .clr(state_d != state_q), .en(cnt_en), .term(term), .hit(hit)
  );
  always_comb begin
    cnt_en = bus.shift_strobe && (state_q == DATA || state_q == STOP);
    term = state_q == DATA ? CW'(DATA_BITS - 1) : CW'(STOP_BITS - 1);
  end
`ifdef RX_PARITY_EN
  logic par_q, par_d;
  always_comb begin
    par_d = state_q == PARITY && bus.shift_strobe ? bus.serial_in : par_q;
    par_err = PARITY_MODE == PAR_EVEN ? ^{sr_q, par_q} :
              PARITY_MODE == PAR_ODD  ? ~^{sr_q, par_q} : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else par_q <= par_d;
  end
`else
  always_comb par_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    stop_ok_d = stop_ok_q;
    case (state_q)
      IDLE: begin
        state_d = bus.frame_start ? DATA : IDLE;
        stop_ok_d = 1'b1;
      end
      DATA: if (bus.shift_strobe) begin
        sr_d = {bus.serial_in, sr_q[DATA_BITS-1:1]};
        state_d = hit ? (USE_PAR ? PARITY : STOP) : DATA;
      end
`ifdef RX_PARITY_EN
      PARITY: state_d = bus.shift_strobe ? STOP : PARITY;
`endif
      STOP: if (bus.shift_strobe) begin
        stop_ok_d = stop_ok_q & bus.serial_in;
        state_d = hit ? DONE : STOP;
      end
      default: state_d = IDLE;
    endcase
  end
  // A completion with a concurrent read keeps data_valid and never flags overrun
  always_comb begin
    done = state_q == DONE;
    packet_data_d = done ? sr_q : packet_data_q;
    framing_error_d = done ? !stop_ok_q : framing_error_q;
    parity_error_d = done ? par_err : parity_error_q;
    data_valid_d = done || (data_valid_q && !bus.data_read);
    overrun_error_d = done && data_valid_q && !bus.data_read ? 1'b1 :
                      bus.data_read && data_valid_q ? 1'b0 : overrun_error_q;
    frame_done_d = done;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      stop_ok_q <= 1'b0;
      packet_data_q <= '0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      stop_ok_q <= stop_ok_d;
      packet_data_q <= packet_data_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      framing_error_q <= framing_error_d;
      parity_error_q <= parity_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end
  always_comb begin
    bus.packet_data = packet_data_q;
    bus.data_valid = data_valid_q;
    bus.frame_done = frame_done_q;
    bus.framing_error = framing_error_q;
    bus.parity_error = parity_error_q;
    bus.overrun_error = overrun_error_q;
    bus.busy = state_q != IDLE;
  end
endmodule

// File: tb/tb_rx_frame_sr.sv
// tb_rx_frame_sr: four configurations of rx_frame_sr checked against a frame-level model
module tb_rx_frame_sr;
  import rx_frame_pkg::*;
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int DB [4] = '{8, 5, 8, 7};
  localparam int SB [4] = '{1, 2, 1, 1};
  localparam parity_mode_t PM [4] = '{PAR_NONE, PAR_NONE, PAR_EVEN, PAR_ODD};
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] fs = '0, st = '0, si = '0, rd = '0;
  logic [21:0] o [4];
  int n_cmp = 0, n_bad = 0;
  logic [15:0] exp_pkt [4];
  bit exp_valid [4], exp_ovr [4], exp_fe [4], exp_pe [4];
  always #5 clk = ~clk;

  rx_frame_sr_if #(.DATA_BITS(8)) i0 ();
  rx_frame_sr_if #(.DATA_BITS(5)) i1 ();
  rx_frame_sr_if #(.DATA_BITS(8)) i2 ();
  rx_frame_sr_if #(.DATA_BITS(7)) i3 ();
  rx_frame_sr #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(PAR_NONE)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  rx_frame_sr #(.DATA_BITS(5), .STOP_BITS(2), .PARITY_MODE(PAR_NONE)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  rx_frame_sr #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(PAR_EVEN)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));
  rx_frame_sr #(.DATA_BITS(7), .STOP_BITS(1), .PARITY_MODE(PAR_ODD)) u3 (.clk(clk), .rst(rst), .bus(i3.slave));
  assign {i0.frame_start, i0.shift_strobe, i0.serial_in, i0.data_read} = {fs[0], st[0], si[0], rd[0]};
  assign {i1.frame_start, i1.shift_strobe, i1.serial_in, i1.data_read} = {fs[1], st[1], si[1], rd[1]};
  assign {i2.frame_start, i2.shift_strobe, i2.serial_in, i2.data_read} = {fs[2], st[2], si[2], rd[2]};
  assign {i3.frame_start, i3.shift_strobe, i3.serial_in, i3.data_read} = {fs[3], st[3], si[3], rd[3]};
  assign o[0] = {i0.busy, i0.overrun_error, i0.parity_error, i0.framing_error, i0.frame_done, i0.data_valid, 16'(i0.packet_data)};
  assign o[1] = {i1.busy, i1.overrun_error, i1.parity_error, i1.framing_error, i1.frame_done, i1.data_valid, 16'(i1.packet_data)};
  assign o[2] = {i2.busy, i2.overrun_error, i2.parity_error, i2.framing_error, i2.frame_done, i2.data_valid, 16'(i2.packet_data)};
  assign o[3] = {i3.busy, i3.overrun_error, i3.parity_error, i3.framing_error, i3.frame_done, i3.data_valid, 16'(i3.packet_data)};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int c);
    check($sformatf("c%0d_pkt", c), o[c][15:0], exp_pkt[c]);
    check($sformatf("c%0d_valid", c), 16'(o[c][16]), 16'(exp_valid[c]));
    check($sformatf("c%0d_ferr", c), 16'(o[c][18]), 16'(exp_fe[c]));
    check($sformatf("c%0d_perr", c), 16'(o[c][19]), 16'(exp_pe[c]));
    check($sformatf("c%0d_ovr", c), 16'(o[c][20]), 16'(exp_ovr[c]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp_pkt[c] = '0;
      exp_valid[c] = 0;
      exp_ovr[c] = 0;
      exp_fe[c] = 0;
      exp_pe[c] = 0;
      check_all(c);
      check($sformatf("c%0d_rst_done", c), 16'(o[c][17]), 16'd0);
      check($sformatf("c%0d_rst_busy", c), 16'(o[c][21]), 16'd0);
    end
  endtask

  task automatic read_pulse(input int c);
    rd[c] = 1'b1;
    tick();
    rd[c] = 1'b0;
    if (exp_valid[c]) begin
      exp_valid[c] = 0;
      exp_ovr[c] = 0;
    end
    check_all(c);
  endtask

  // s[i] is the i-th stop bit; fs_noise pulses frame_start just before the last bit
  task automatic send_frame(input int c, input logic [15:0] d_in, input logic p, input logic [1:0] s,
                            input bit rd_done, input bit fs_noise);
    logic b[$];
    logic [15:0] d;
    bit hp, fe, x;
    hp = PAR_EN && PM[c] != PAR_NONE;
    d = d_in & ((16'd1 << DB[c]) - 16'd1);
    for (int i = 0; i < DB[c]; i++) b.push_back(d[i]);
    if (hp) b.push_back(p);
    for (int i = 0; i < SB[c]; i++) b.push_back(s[i]);
    if ($urandom_range(1) == 1) begin
      st[c] = 1'b1;
      si[c] = 1'($urandom_range(1));
      tick();
      st[c] = 1'b0;
    end
    fs[c] = 1'b1;
    st[c] = 1'($urandom_range(1));
    si[c] = 1'($urandom_range(1));
    tick();
    fs[c] = 1'b0;
    st[c] = 1'b0;
    check($sformatf("c%0d_busy_start", c), 16'(o[c][21]), 16'd1);
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(2)) tick();
      if (fs_noise && i == b.size() - 1) begin
        fs[c] = 1'b1;
        tick();
        fs[c] = 1'b0;
      end
      st[c] = 1'b1;
      si[c] = b[i];
      tick();
      st[c] = 1'b0;
    end
    if (rd_done) rd[c] = 1'b1;
    check($sformatf("c%0d_done_early", c), 16'(o[c][17]), 16'd0);
    tick();
    rd[c] = 1'b0;
    fe = 0;
    for (int i = 0; i < SB[c]; i++) if (!s[i]) fe = 1;
    x = ^d ^ p;
    if (exp_valid[c]) exp_ovr[c] = !rd_done;
    exp_valid[c] = 1;
    exp_pkt[c] = d;
    exp_fe[c] = fe;
    exp_pe[c] = hp && (PM[c] == PAR_EVEN ? x : !x);
    check($sformatf("c%0d_done", c), 16'(o[c][17]), 16'd1);
    check_all(c);
    tick();
    check($sformatf("c%0d_done_pulse", c), 16'(o[c][17]), 16'd0);
    check($sformatf("c%0d_busy_end", c), 16'(o[c][21]), 16'd0);
  endtask

  initial begin
    repeat (3) tick();
    do_reset();
    send_frame(0, 16'hA5, 1'b0, 2'b11, 0, 0);
    send_frame(0, 16'hA5, 1'b0, 2'b10, 0, 0);
    read_pulse(0);
    send_frame(0, 16'h3C, 1'b0, 2'b11, 0, 0);
    read_pulse(0);
    send_frame(0, 16'h11, 1'b0, 2'b11, 0, 0);
    send_frame(0, 16'h22, 1'b0, 2'b11, 0, 0);
    read_pulse(0);
    read_pulse(0);
    fs[0] = 1'b1;
    tick();
    fs[0] = 1'b0;
    repeat (4) begin
      st[0] = 1'b1;
      si[0] = 1'($urandom_range(1));
      tick();
      st[0] = 1'b0;
    end
    do_reset();
    tick();
    check("c0_no_done_after_rst", 16'(o[0][17]), 16'd0);
    send_frame(0, 16'h3C, 1'b0, 2'b11, 0, 0);
    send_frame(1, 16'h15, 1'b0, 2'b01, 0, 1);
    send_frame(2, 16'h07, 1'b1, 2'b11, 0, 0);
    send_frame(2, 16'h07, 1'b0, 2'b11, 1, 0);
    send_frame(3, 16'h07, 1'b0, 2'b11, 1, 0);
    for (int n = 0; n < 150; n++) begin
      int c;
      c = $urandom_range(3);
      if ($urandom_range(39) == 0) do_reset();
      send_frame(c, 16'($urandom), 1'($urandom_range(1)),
                 $urandom_range(3) != 0 ? 2'b11 : 2'($urandom_range(3)),
                 $urandom_range(4) == 0, $urandom_range(3) == 0);
      if ($urandom_range(1) == 1) read_pulse(c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rx_frame_sr.md
# rx_frame_sr

Parametrised receive-frame shift register for the UART receive path. It accepts sampled serial bits on strobes from the timer block, captures a frame of configurable data width with optional parity and one or two stop bits, and checks framing and parity. It holds the completed word for the consumer behind a valid/read handshake with overrun detection, and sits between the start-bit detector/timer and the receive data register.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..9
- STOP_BITS, 1: stop bits per frame, legal 1 or 2
- PARITY_MODE, PAR_NONE: PAR_NONE / PAR_EVEN / PAR_ODD; only honoured with the parity macro
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse: start bit validated, begin capture
- shift_strobe  in  1  one-cycle pulse at each bit sample point after the start bit
- serial_in  in  1  synchronised serial line
- data_read  in  1  consumer acknowledges packet_data
- packet_data  out  DATA_BITS  last completed frame's data, LSB = first received bit
- data_valid  out  1  packet_data unread
- frame_done  out  1  one-cycle pulse per completed frame
- framing_error  out  1  last frame had a stop bit sampled 0
- parity_error  out  1  last frame failed parity check
- overrun_error  out  1  frame completed while previous data unread (sticky)
- busy  out  1  frame capture in progress

## Operation
- FSM states: IDLE, DATA, PARITY, STOP, DONE.
- IDLE: frame_start goes to DATA and clears the bit counter. shift_strobe is ignored.
- DATA: each strobe shifts serial_in into the MSB of the DATA_BITS shift register, shifting right, so the frame is LSB-first. After DATA_BITS strobes the FSM goes to PARITY if parity is enabled and PARITY_MODE != PAR_NONE, otherwise to STOP.
- PARITY: one strobe latches the parity bit.
- STOP: each strobe ANDs serial_in into a stop_ok flag. After STOP_BITS strobes the FSM goes to DONE.
- DONE: lasts exactly one cycle, then IDLE. On the edge leaving DONE:
  - packet_data <= shift register
  - framing_error <= !stop_ok
  - parity_error <= check result
  - data_valid <= 1
  - frame_done = 1 for the next cycle
- Parity check:
  - EVEN: error if XOR(data, parity bit) = 1.
  - ODD: error if XOR = 0.
- Errors are not sticky. They are rewritten at every completion and held until the next one. Data is loaded even when errors are flagged.
- Handshake: data_read while data_valid=1 clears data_valid, and clears overrun_error, on the next edge. data_read while data_valid=0 has no effect.
- Overrun: if a completion occurs while data_valid=1 and data_read=0, then packet_data is overwritten and overrun_error <= 1.
- Completion and data_read in the same cycle: data_valid stays 1, overrun is not set, and overrun_error is cleared.
- frame_start while busy or in DONE is ignored.
- busy = 1 in DATA, PARITY, STOP, DONE.

## Timing
- Reset (rst high at an edge):
  - FSM goes to IDLE; counter and shift register go to 0.
  - All outputs go to 0: packet_data, data_valid, frame_done, framing_error, parity_error, overrun_error, busy.
  - A frame in progress is discarded and no frame_done is produced.
- A strobe in cycle t is sampled at the edge ending t.
- Final stop strobe in cycle k: DONE in k+1; frame_done, data_valid and packet_data visible in k+2. Latency is 2 cycles.
- frame_start in cycle t: busy=1 in t+1. A shift_strobe in the same cycle t is not counted.
- Bit counter width is $clog2(max(DATA_BITS, STOP_BITS)+1). It is cleared on every state entry.

## Configuration
- RX_PARITY_EN defined:
  - The PARITY state and parity logic exist, and PARITY_MODE selects behaviour.
  - PAR_NONE means no parity slot in the frame.
- RX_PARITY_EN undefined:
  - No PARITY state and no parity logic.
  - PARITY_MODE is ignored; frames never contain a parity bit.
  - parity_error is tied 0.

## Structure
- Package rx_frame_pkg holds:
  - parity_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD)
  - rx_state_t enum
  - constants MIN_DATA_BITS=5, MAX_DATA_BITS=9
- One sub-module, rx_bit_counter, which is a parametrised strobe-enabled counter with sync clear and a terminal-count compare input. It is instantiated once and reused across DATA and STOP.

## Test plan
- DATA_BITS=8, STOP_BITS=1, no parity: frame_start, then strobes on 1,0,1,0,0,1,0,1 and stop=1 -> two cycles after the last strobe: packet_data=0xA5, frame_done one-cycle pulse, data_valid=1, all error flags 0.
- Same frame with stop sampled 0 -> packet_data=0xA5, framing_error=1. The next good frame clears framing_error to 0.
- RX_PARITY_EN, PAR_EVEN, data 0x07:
  - Parity bit 1 -> parity_error=0.
  - Parity bit 0 -> parity_error=1.
  - PAR_ODD with parity bit 0 -> parity_error=0.
- Frames 0x11 then 0x22 with no data_read -> overrun_error=1, packet_data=0x22. A data_read pulse then gives data_valid=0 and overrun_error=0 next cycle.
- rst asserted after 4 data strobes -> busy=0, no frame_done. A following full 0x3C frame is received correctly.
- DATA_BITS=5, STOP_BITS=2, data 0x15, stops 1,0 -> packet_data=5'h15, framing_error=1. A frame_start pulse during STOP is ignored.
